cube_layer_scanner: RTL and testbench

//  Consumer end of the refresh-tick interface. Takes the slow refresh square wave from the

---
 rtl/cube_pkg.sv | 19 +
 rtl/refresh_edge_sync.sv | 39 +++
 rtl/cube_layer_scanner.sv | 140 ++++++++++++++
 tb/tb_cube_layer_scanner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared definitions for the LED cube layer scanner: default geometry, timing and FSM encoding.
package cube_pkg;

  localparam int unsigned CUBE_N_DEF       = 4;
  localparam int unsigned BLANK_CYCLES_DEF = 500;
  localparam int unsigned SYNC_STAGES_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Index width for a layer counter; never collapses to zero bits for a 1-layer cube.
  function automatic int unsigned layer_addr_bits(input int unsigned layers);
    return (layers > 1) ? $clog2(layers) : 1;
  endfunction

endpackage

// File: rtl/refresh_edge_sync.sv
// Synchronises the refresh square wave and emits a registered one-cycle step pulse on either edge.
module refresh_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic step
);

  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned AW         = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [AW-1:0]          arm_cnt;
  logic                   armed;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];
  assign armed  = (arm_cnt == AW'(ARM_CYCLES));

  // prev keeps tracking the synchroniser while disarmed, so a level that was
  // already high during reset is absorbed instead of reported as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '0;
      prev    <= 1'b0;
      arm_cnt <= '0;
      step    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], level};
      prev <= synced;
      if (!armed) arm_cnt <= arm_cnt + AW'(1);
      step <= armed && (synced != prev);
    end
  end

endmodule

// File: rtl/cube_layer_scanner.sv
// Scans a CUBE_N^3 LED cube layer by layer from refresh steps, with blanking between layers
// and a double-buffered frame store swapped only at frame boundaries.
module cube_layer_scanner
  import cube_pkg::*;
#(
  parameter int unsigned CUBE_N       = CUBE_N_DEF,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic                         clk_50MHz,
  input  logic                         reset,
  input  logic                         refresh_clk,
  input  logic                         wr_en,
  input  logic [$clog2(CUBE_N+1)-1:0]  wr_layer,
  input  logic [CUBE_N*CUBE_N-1:0]     wr_data,
  input  logic                         swap_req,
  output logic                         swap_pending,
  output logic                         swap_ack,
  output logic [CUBE_N-1:0]            layer_sel,
  output logic [CUBE_N*CUBE_N-1:0]     col_data,
  output logic                         frame_start,
  output logic                         overrun
);

  localparam int unsigned LAYERS = CUBE_N;
  localparam int unsigned COLS   = CUBE_N * CUBE_N;
  localparam int unsigned AW     = layer_addr_bits(LAYERS);
  localparam int unsigned WLW    = $clog2(LAYERS + 1);
  localparam int unsigned BCW    = $clog2(BLANK_CYCLES + 1);

  scan_state_t     state;
  logic [AW-1:0]   cur_layer;
  logic [AW-1:0]   next_layer;
  logic            last_layer;
  logic [BCW-1:0]  blank_cnt;
  logic            front;
  logic            back;
  logic            step;
  logic            wr_hit;
  logic [AW-1:0]   wr_idx;
  logic [COLS-1:0] bufs [2][LAYERS];

  function automatic logic [LAYERS-1:0] onehot(input logic [AW-1:0] idx);
    logic [LAYERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  refresh_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk_50MHz),
    .reset (reset),
    .level (refresh_clk),
    .step  (step)
  );

  // wr_layer is one bit wider than a layer index so out-of-range targets are
  // representable and can be rejected rather than aliased onto a real layer.
  assign wr_hit     = wr_en && (wr_layer < WLW'(LAYERS));
  assign wr_idx     = wr_layer[AW-1:0];
  assign back       = ~front;
  assign last_layer = (cur_layer == AW'(LAYERS - 1));
  assign next_layer = last_layer ? '0 : cur_layer + AW'(1);

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned l = 0; l < LAYERS; l++) begin
          bufs[b][l] <= '0;
        end
      end
    end else if (wr_hit) begin
      bufs[back][wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state        <= IDLE;
      cur_layer    <= '0;
      blank_cnt    <= '0;
      layer_sel    <= '0;
      col_data     <= '0;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      frame_start  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      if (swap_req) swap_pending <= 1'b1;

      unique case (state)
        IDLE: begin
          if (step) begin
            state       <= DRIVE;
            cur_layer   <= '0;
            layer_sel   <= onehot('0);
            col_data    <= bufs[front][0];
            frame_start <= 1'b1;
          end
        end

        DRIVE: begin
          if (step) begin
            state     <= BLANK;
            layer_sel <= '0;
            col_data  <= '0;
            blank_cnt <= BCW'(1);
            cur_layer <= next_layer;
            // A request landing on the swap cycle re-arms pending for the next frame.
            if (last_layer && swap_pending) begin
              front        <= ~front;
              swap_pending <= swap_req;
              swap_ack     <= 1'b1;
            end
          end
        end

        BLANK: begin
          if (step) overrun <= 1'b1;
          if (blank_cnt == BCW'(BLANK_CYCLES)) begin
            state       <= DRIVE;
            layer_sel   <= onehot(cur_layer);
            col_data    <= bufs[front][cur_layer];
            frame_start <= (cur_layer == '0);
          end else begin
            blank_cnt <= blank_cnt + BCW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_layer_scanner.sv
// Directed bench for cube_layer_scanner with CUBE_N=4, BLANK_CYCLES=4, SYNC_STAGES=2.
module tb_cube_layer_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        refresh_clk;
  logic        wr_en;
  logic [2:0]  wr_layer;
  logic [15:0] wr_data;
  logic        swap_req;
  logic        swap_pending;
  logic        swap_ack;
  logic [3:0]  layer_sel;
  logic [15:0] col_data;
  logic        frame_start;
  logic        overrun;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  cur_sel = 4'b0000;

  cube_layer_scanner #(
    .CUBE_N      (4),
    .BLANK_CYCLES(4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_50MHz   (clk),
    .reset       (reset),
    .refresh_clk (refresh_clk),
    .wr_en       (wr_en),
    .wr_layer    (wr_layer),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_pending(swap_pending),
    .swap_ack    (swap_ack),
    .layer_sel   (layer_sel),
    .col_data    (col_data),
    .frame_start (frame_start),
    .overrun     (overrun)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_row(input logic [2:0] l, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_layer = l; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap(input string tag);
    @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    check({tag, "_pend"}, swap_pending, 1);
  endtask

  // First step out of IDLE: no blank, layer 0 driven three edges after the sampling edge.
  task automatic start_step(input string tag, input logic [15:0] ecol);
    @(negedge clk);
    refresh_clk = ~refresh_clk;
    repeat (3) @(negedge clk);
    check({tag, "_lat"}, layer_sel, 0);
    @(negedge clk);
    check({tag, "_sel"}, layer_sel, 4'b0001);
    check({tag, "_fs"}, frame_start, 1);
    check({tag, "_col"}, col_data, ecol);
    @(negedge clk);
    check({tag, "_fs_pulse"}, frame_start, 0);
    cur_sel = 4'b0001;
    repeat (20) @(negedge clk);
  endtask

  // DRIVE->BLANK->DRIVE step; optional write / swap request / extra toggle on the DRIVE->BLANK edge.
  task automatic layer_step(input string tag, input logic [3:0] esel, input logic efs,
                            input logic [15:0] ecol, input logic eack, input logic epend,
                            input bit side_wr, input logic [2:0] sl, input logic [15:0] sd,
                            input bit side_swap, input bit side_tog);
    @(negedge clk);
    refresh_clk = ~refresh_clk;
    repeat (3) @(negedge clk);
    check({tag, "_lat"}, layer_sel, cur_sel);
    if (side_wr) begin
      wr_en = 1'b1; wr_layer = sl; wr_data = sd;
    end
    if (side_swap) swap_req = 1'b1;
    if (side_tog) refresh_clk = ~refresh_clk;
    @(negedge clk);
    wr_en = 1'b0; swap_req = 1'b0;
    check({tag, "_blank_sel"}, layer_sel, 0);
    check({tag, "_blank_col"}, col_data, 0);
    check({tag, "_ack"}, swap_ack, eack);
    check({tag, "_pend"}, swap_pending, epend);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_blank_hold"}, layer_sel, 0);
    end
    @(negedge clk);
    check({tag, "_sel"}, layer_sel, esel);
    check({tag, "_fs"}, frame_start, efs);
    check({tag, "_col"}, col_data, ecol);
    cur_sel = esel;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; refresh_clk = 1'b1; wr_en = 1'b0; wr_layer = '0; wr_data = '0; swap_req = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_sel", layer_sel, 0);
    check("rst_col", col_data, 0);
    check("rst_fs", frame_start, 0);
    check("rst_pend", swap_pending, 0);
    check("rst_ack", swap_ack, 0);
    check("rst_ovr", overrun, 0);

    // 1: high refresh level at reset release must not look like an edge
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t1_idle_sel", layer_sel, 0);
    end
    check("t1_idle_fs", frame_start, 0);

    // 2: plain scan across one frame and back to layer 0
    start_step("t2_l0", 16'h0000);
    layer_step("t2_l1", 4'b0010, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t2_l2", 4'b0100, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t2_l3", 4'b1000, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t2_l0b", 4'b0001, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);

    // 3: fill back buffer, swap requested mid-layer 2, takes effect next frame
    write_row(3'd0, 16'hAAAA);
    write_row(3'd1, 16'h5555);
    write_row(3'd2, 16'hF0F0);
    write_row(3'd3, 16'h0F0F);
    @(negedge clk);
    check("t3_no_tear", col_data, 16'h0000);
    layer_step("t3_l1", 4'b0010, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t3_l2", 4'b0100, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    pulse_swap("t3_req");
    layer_step("t3_l3", 4'b1000, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
    layer_step("t3_l0", 4'b0001, 1, 16'hAAAA, 1, 0, 0, 0, 0, 0, 0);
    layer_step("t3_l1b", 4'b0010, 0, 16'h5555, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t3_l2b", 4'b0100, 0, 16'hF0F0, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t3_l3b", 4'b1000, 0, 16'h0F0F, 0, 0, 0, 0, 0, 0, 0);

    // 5: invalid layer write ignored; write and repeat request on the swap cycle
    write_row(3'd4, 16'hFFFF);
    pulse_swap("t5_req");
    layer_step("t5_l0", 4'b0001, 1, 16'h0000, 1, 1, 1, 3'd1, 16'h1234, 1, 0);
    layer_step("t5_l1", 4'b0010, 0, 16'h1234, 0, 1, 0, 0, 0, 0, 0);
    layer_step("t5_l2", 4'b0100, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
    layer_step("t5_l3", 4'b1000, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
    layer_step("t5_l0b", 4'b0001, 1, 16'hAAAA, 1, 0, 0, 0, 0, 0, 0);

    // 4: extra edge inside blank sets sticky overrun, sequence continues unskipped
    check("t4_ovr_before", overrun, 0);
    layer_step("t4_l1", 4'b0010, 0, 16'h5555, 0, 0, 0, 0, 0, 0, 1);
    check("t4_ovr_set", overrun, 1);
    layer_step("t4_l2", 4'b0100, 0, 16'hF0F0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_ovr_sticky", overrun, 1);
    layer_step("t4_l3", 4'b1000, 0, 16'h0F0F, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t4_l0", 4'b0001, 1, 16'hAAAA, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t4_l1b", 4'b0010, 0, 16'h5555, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t4_l2b", 4'b0100, 0, 16'hF0F0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_ovr_still", overrun, 1);

    // 6: reset while driving layer 2, then both buffers must display as zero
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_sel", layer_sel, 0);
    check("t6_col", col_data, 0);
    check("t6_ovr", overrun, 0);
    check("t6_pend", swap_pending, 0);
    check("t6_fs", frame_start, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_sel = 4'b0000;
    repeat (10) @(negedge clk);
    check("t6_idle", layer_sel, 0);
    start_step("t6_l0", 16'h0000);
    layer_step("t6_l1", 4'b0010, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t6_l2", 4'b0100, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t6_l3", 4'b1000, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    pulse_swap("t6_req");
    layer_step("t6_l0b", 4'b0001, 1, 16'h0000, 1, 0, 0, 0, 0, 0, 0);
    layer_step("t6_l1b", 4'b0010, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    layer_step("t6_l2b", 4'b0100, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    check("t6_ovr_end", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
